// File: rtl/pll_reset_seq.sv
// PLL start-up sequencer: pulses PLL RESETB, waits for a synchronised lock that
// stays stable, then releases the system reset. Retries on lock timeout, latches FAIL.
module pll_reset_seq #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1200,
  parameter int unsigned STABLE_CYCLES = 64,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic       clock_in,
  input  logic       resetn,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_resetb,
  output logic       sys_rst_n,
  output logic       ready,
  output logic       error,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_t;

  // Counter holds cycles already spent in the state, so "last" is N-1.
  localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);

  state_t      state_reg, state_next;
  logic [15:0] cnt_reg, cnt_next;
  logic [3:0]  retry_reg, retry_next;
  logic [1:0]  sync_reg;
  logic        lock_s;
  logic        entry;
  logic        pll_resetb_next, sys_rst_n_next, ready_next, error_next;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      sync_reg <= 2'b00;
    end else begin
      sync_reg <= {sync_reg[0], locked};
    end
  end

  assign lock_s = sync_reg[1];

  // State register; outputs are registered from their next values.
  always_ff @(posedge clock_in or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= RESET_PLL;
      cnt_reg     <= 16'd0;
      retry_reg   <= 4'd0;
      pll_resetb  <= 1'b0;
      sys_rst_n   <= 1'b0;
      ready       <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      pll_resetb  <= pll_resetb_next;
      sys_rst_n   <= sys_rst_n_next;
      ready       <= ready_next;
      error       <= error_next;
    end
  end

  assign retry_count = retry_reg;

  // Next-state logic; restart overrides every other transition.
  always_comb begin
    state_next = state_reg;
    retry_next = retry_reg;
    if (restart) begin
      state_next = RESET_PLL;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        RESET_PLL: begin
          if (cnt_reg >= RST_LAST) begin
            state_next = WAIT_LOCK;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_next = STABLE;
          end else if (cnt_reg >= TIMEOUT_LAST) begin
            if (retry_reg >= RETRY_MAX) begin
              state_next = FAIL;
            end else begin
              state_next = RESET_PLL;
              retry_next = retry_reg + 4'd1;
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_next = WAIT_LOCK;
          end else if (cnt_reg >= STABLE_LAST) begin
            state_next = RUN;
            retry_next = 4'd0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_next = RESET_PLL;
          end
        end
        FAIL: begin
          state_next = FAIL;
        end
        default: begin
          state_next = RESET_PLL;
        end
      endcase
    end
  end

  // Restart into RESET_PLL counts as a fresh entry even when already there.
  assign entry = restart || (state_next != state_reg);

  always_comb begin
    cnt_next = cnt_reg;
    if (entry) begin
      cnt_next = 16'd0;
    end else if (cnt_reg != 16'hFFFF) begin
      cnt_next = cnt_reg + 16'd1;
    end
  end

  // Output decode from the upcoming state so outputs line up with the state register.
  always_comb begin
    pll_resetb_next = 1'b1;
    sys_rst_n_next  = 1'b0;
    ready_next      = 1'b0;
    error_next      = 1'b0;
    case (state_next)
      RESET_PLL: pll_resetb_next = 1'b0;
      RUN: begin
        sys_rst_n_next = 1'b1;
        ready_next     = 1'b1;
      end
      FAIL:      error_next = 1'b1;
      default: begin
        pll_resetb_next = 1'b1;
      end
    endcase
  end

endmodule

// File: doc/pll_reset_seq.md
PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the number of cycles pll_resetb is held low per PLL reset attempt (valid range 1..65535).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 1200, giving the cycles to wait for lock after pll_resetb rises (100 us at 12 MHz; valid range 1..65535).
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 64, giving the cycles lock must stay continuously high before release (valid range 1..65535).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, giving the PLL reset retries allowed after the first attempt before failure (valid range 0..15).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clock_in input 1 (12 MHz board clock, the same pin that feeds the PLL); resetn input 1 (asynchronous, active-low).
REQ-006 The block SHALL have: locked input 1 (PLL LOCK, asynchronous to clock_in); restart input 1 (synchronous single-cycle request to re-sequence).
REQ-007 The block SHALL have: pll_resetb output 1 (to PLL RESETB); sys_rst_n output 1 (active-low system reset); ready output 1; error output 1; retry_count output 4.

Function
REQ-008 locked SHALL pass through a 2-flop synchronizer to give lock_s; all decisions SHALL use lock_s only.
REQ-009 The FSM SHALL have exactly the states RESET_PLL, WAIT_LOCK, STABLE, RUN and FAIL, with one 16-bit cycle counter cleared on every state entry.
REQ-010 In RESET_PLL: pll_resetb=0; once the counter has counted RST_CYCLES cycles, the FSM SHALL go to WAIT_LOCK.
REQ-011 In WAIT_LOCK: pll_resetb=1; lock_s=1 SHALL go to STABLE.
REQ-012 In WAIT_LOCK, if the counter reaches LOCK_TIMEOUT with lock_s=0: when retry_count==MAX_RETRY the FSM SHALL go to FAIL; otherwise retry_count SHALL increment and the FSM SHALL go to RESET_PLL.
REQ-013 In STABLE: lock_s=0 SHALL return to WAIT_LOCK, with a fresh timeout and retry_count unchanged; STABLE_CYCLES consecutive cycles with lock_s=1 SHALL go to RUN.
REQ-014 In RUN: sys_rst_n=1 and ready=1; lock_s=0 SHALL go to RESET_PLL, with sys_rst_n=0 and ready=0 from the next clock edge.
REQ-015 On entry to RUN, retry_count SHALL clear to 0.
REQ-016 In FAIL: pll_resetb=1, sys_rst_n=0, ready=0, error=1; the FSM SHALL remain in FAIL until restart or resetn.
REQ-017 restart=1 in any state SHALL go to RESET_PLL and clear retry_count and error; restart SHALL take priority over every other transition in the same cycle.
REQ-018 Outside RUN, sys_rst_n SHALL be 0 and ready SHALL be 0.
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-020 sys_rst_n is synchronous to clock_in; PLL-domain consumers re-synchronize it.
REQ-021 The counter SHALL saturate and never wrap.
REQ-022 retry_count SHALL never exceed MAX_RETRY.
REQ-023 With MAX_RETRY=0, the first timeout SHALL go directly to FAIL.

Reset
REQ-024 While resetn=0: state=RESET_PLL, counter=0, synchronizer flops=0, pll_resetb=0, sys_rst_n=0, ready=0, error=0, retry_count=0.
REQ-025 When resetn is asserted mid-operation, including in RUN or FAIL, all outputs SHALL reach their reset values immediately (asynchronously), and sequencing SHALL restart from RESET_PLL after release.

Verification
REQ-026 Scenario (defaults): locked held 1 from reset release -> pll_resetb low for 16 cycles; sys_rst_n and ready rise no earlier than 16+64 and no later than 16+64+4 cycles after release; error=0.
REQ-027 Scenario: locked held 0 -> exactly 4 pll_resetb low pulses of 16 cycles each, spaced by 1200 high cycles; error=1 after the 4th timeout; retry_count=3; sys_rst_n stays 0.
REQ-028 Scenario: in RUN, locked drops for 1 cycle -> sys_rst_n=0 within 3 cycles; new 16-cycle pll_resetb pulse; with locked back to 1, sys_rst_n returns to 1 after about 80 cycles; retry_count=0.
REQ-029 Scenario: in STABLE, locked glitches low at count 30 -> back to WAIT_LOCK, no pll_resetb pulse; with locked then stable, the full 64-cycle STABLE window restarts before RUN.
REQ-030 Scenario: in FAIL, a restart pulse arrives together with locked=1 -> error=0 next cycle; retry_count=0; normal sequence to RUN.
REQ-031 Scenario: resetn pulsed low for 1 cycle while in RUN -> sys_rst_n and ready go 0 asynchronously, then the full sequence repeats after release.
